// File: rtl/sif_arb_pkg.sv
// rtl/sif_arb_pkg.sv - shared types, defaults and round-robin helper for sif_arbiter
package sif_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } state_t;

  localparam int AW_DEF  = 16;
  localparam int DW_DEF  = 16;
  localparam int MAX_MST = 8;

  // One-hot first set bit of req strictly after ptr, wrapping modulo n (n <= MAX_MST).
  function automatic logic [MAX_MST-1:0] next_rr(input logic [MAX_MST-1:0] req,
                                                 input logic [2:0]         ptr,
                                                 input int                 n);
    logic [MAX_MST-1:0] win;
    logic [3:0]         idx;
    logic               found;
    win   = '0;
    found = 1'b0;
    for (int k = 1; k <= MAX_MST; k++) begin
      if (k <= n) begin
        idx = {1'b0, ptr} + 4'(k);
        if (idx >= 4'(n)) idx = idx - 4'(n);
        if (!found && req[idx[2:0]]) begin
          win[idx[2:0]] = 1'b1;
          found         = 1'b1;
        end
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/sif_arbiter_rr_pick.sv
// rtl/sif_arbiter_rr_pick.sv - combinational round-robin selector (one-hot and index)
module rr_pick
  import sif_arb_pkg::*;
#(
  parameter int N_MST = 2,
  parameter int PW    = 1
) (
  input  logic [N_MST-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_MST-1:0] win,
  output logic [PW-1:0]    win_idx
);

  logic [MAX_MST-1:0] w_req_ext;
  logic [MAX_MST-1:0] w_win_ext;
  logic [2:0]         w_ptr_ext;

  assign w_req_ext = MAX_MST'(req);
  assign w_ptr_ext = 3'(ptr);
  assign w_win_ext = next_rr(w_req_ext, w_ptr_ext, N_MST);
  assign win       = w_win_ext[N_MST-1:0];

  // Bits above N_MST are always zero because the extended request is zero there.
  if (N_MST < MAX_MST) begin : g_spare
    logic [MAX_MST-N_MST-1:0] w_unused_hi;
    assign w_unused_hi = w_win_ext[MAX_MST-1:N_MST];
  end

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < N_MST; i++) begin
      if (win[i]) win_idx = PW'(i);
    end
  end

endmodule

// File: rtl/sif_arbiter.sv
// rtl/sif_arbiter.sv - round-robin arbiter sharing one SIF target port among N_MST masters
module sif_arbiter
  import sif_arb_pkg::*;
#(
  parameter int N_MST  = 2,
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int RD_LAT = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_MST-1:0]    req,
  input  logic [N_MST-1:0]    we,
  input  logic [N_MST*AW-1:0] addr,
  input  logic [N_MST*DW-1:0] wdata,
  output logic [N_MST-1:0]    gnt,
  output logic [N_MST-1:0]    rvalid,
  output logic [DW-1:0]       rdata,
  output logic                busy,
  output logic                xa_wr_s,
  output logic                xa_rd_s,
  output logic [AW-1:0]       xa_addr,
  output logic [DW-1:0]       xa_data_wr,
  input  logic [DW-1:0]       xa_data_rd
);

  localparam int PW = $clog2(N_MST);

  if (RD_LAT < 1 || RD_LAT > 15) begin : g_bad_rd_lat
    $error("sif_arbiter: RD_LAT must be within 1..15");
  end
  if (N_MST < 2 || N_MST > MAX_MST) begin : g_bad_n_mst
    $error("sif_arbiter: N_MST must be within 2..8");
  end

  state_t           r_state;
  logic [PW-1:0]    r_ptr;
  logic [PW-1:0]    r_owner;
  logic             r_we;
  logic [3:0]       r_cnt;

  logic [N_MST-1:0] w_win;
  logic [PW-1:0]    w_win_idx;
  logic [AW-1:0]    w_addr;
  logic [DW-1:0]    w_wdata;
  logic             w_we;

  rr_pick #(
    .N_MST (N_MST),
    .PW    (PW)
  ) u_rr_pick (
    .req     (req),
    .ptr     (r_ptr),
    .win     (w_win),
    .win_idx (w_win_idx)
  );

  always_comb begin
    w_addr  = '0;
    w_wdata = '0;
    w_we    = 1'b0;
    for (int i = 0; i < N_MST; i++) begin
      if (w_win[i]) begin
        w_addr  = addr[i*AW +: AW];
        w_wdata = wdata[i*DW +: DW];
        w_we    = we[i];
      end
    end
  end

  assign gnt  = (r_state == IDLE && !rst) ? w_win : '0;
  assign busy = (r_state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ptr      <= PW'(N_MST - 1);
      r_owner    <= '0;
      r_we       <= 1'b0;
      r_cnt      <= '0;
      xa_wr_s    <= 1'b0;
      xa_rd_s    <= 1'b0;
      xa_addr    <= '0;
      xa_data_wr <= '0;
      rdata      <= '0;
      rvalid     <= '0;
    end else begin
      xa_wr_s <= 1'b0;
      xa_rd_s <= 1'b0;
      rvalid  <= '0;
      case (r_state)
        IDLE: begin
          if (|req) begin
            xa_addr    <= w_addr;
            xa_data_wr <= w_we ? w_wdata : xa_data_wr;
            r_owner    <= w_win_idx;
            r_we       <= w_we;
            r_ptr      <= w_win_idx;
            // Strobes are registered here so they are high during ISSUE.
            xa_wr_s    <= w_we;
            xa_rd_s    <= !w_we;
            r_state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (r_we) begin
            r_state <= IDLE;
          end else begin
            r_cnt   <= 4'(RD_LAT - 1);
            r_state <= WAIT_RD;
          end
        end
        WAIT_RD: begin
          if (r_cnt == 4'd0) begin
            rdata   <= xa_data_rd;
            rvalid  <= N_MST'(1) << r_owner;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sif_arbiter.sv
// tb/tb_sif_arbiter.sv - self-checking bench for sif_arbiter with a transaction-level model
module tb_sif_arbiter;

  localparam int NM     = 4;
  localparam int RD_LAT = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [NM-1:0]  req, we, gnt, rvalid;
  logic [NM*16-1:0] addr, wdata;
  logic [15:0]    rdata, xa_addr, xa_data_wr, xa_data_rd;
  logic           busy, xa_wr_s, xa_rd_s;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int m_last = NM - 1;
  logic [15:0] last_wd = '0;
  logic        m_we   [NM];
  logic [15:0] m_addr [NM];
  logic [15:0] m_wd   [NM];

  sif_arbiter #(.N_MST(NM), .AW(16), .DW(16), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .busy(busy),
    .xa_wr_s(xa_wr_s), .xa_rd_s(xa_rd_s), .xa_addr(xa_addr),
    .xa_data_wr(xa_data_wr), .xa_data_rd(xa_data_rd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Target model: data depends on the address and the current cycle, so the sample cycle is visible.
  function automatic logic [15:0] tgt_fn(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hA5C3;
  endfunction
  assign xa_data_rd = tgt_fn(xa_addr) ^ cyc[15:0];

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [NM-1:0] m, input int last);
    int r = -1;
    for (int k = 1; k <= NM; k++) begin
      if (r < 0 && m[(last + k) % NM]) r = (last + k) % NM;
    end
    return r;
  endfunction

  task automatic drive(input logic [NM-1:0] m);
    req = m;
    for (int i = 0; i < NM; i++) begin
      we[i]             = m_we[i];
      addr[i*16 +: 16]  = m_addr[i];
      wdata[i*16 +: 16] = m_wd[i];
    end
  endtask

  task automatic randomize_master(input int i);
    m_we[i]   = 1'($urandom_range(0, 1));
    m_addr[i] = 16'($urandom);
    m_wd[i]   = 16'($urandom);
  endtask

  // Serves every pending request; winners may re-request, late requests join during a read.
  task automatic run_batch(input logic [NM-1:0] mask0, input int n_rereq, input logic [NM-1:0] late0);
    logic [NM-1:0] pend, late, exp_rv;
    logic [15:0]   a, d, exp_rd;
    logic          is_wr;
    int            w, gcyc, rereq;
    pend = mask0; late = late0; rereq = n_rereq; exp_rv = '0; exp_rd = '0;
    @(posedge clk); #1;
    drive(pend);
    while (pend != 0) begin
      @(negedge clk);
      w = pick(pend, m_last);
      chk("gnt", 32'(gnt), 32'(NM'(1) << w));
      chk("busy_idle", 32'(busy), 32'd0);
      chk("strobe_idle", 32'({xa_wr_s, xa_rd_s}), 32'd0);
      chk("rvalid", 32'(rvalid), 32'(exp_rv));
      if (exp_rv != 0) chk("rdata", 32'(rdata), 32'(exp_rd));
      gcyc = cyc; m_last = w; is_wr = m_we[w]; a = m_addr[w]; d = m_wd[w];
      @(posedge clk); #1;
      if (rereq > 0) begin
        rereq--;
        m_addr[w] = 16'($urandom);
        m_wd[w]   = 16'($urandom);
      end else begin
        pend[w] = 1'b0;
      end
      drive(pend);
      @(negedge clk);
      chk("xa_wr_s", 32'(xa_wr_s), 32'(is_wr));
      chk("xa_rd_s", 32'(xa_rd_s), 32'(!is_wr));
      chk("xa_addr", 32'(xa_addr), 32'(a));
      if (is_wr) begin
        chk("xa_data_wr", 32'(xa_data_wr), 32'(d));
        last_wd = d;
      end else begin
        chk("xa_data_wr_keep", 32'(xa_data_wr), 32'(last_wd));
      end
      chk("busy_issue", 32'(busy), 32'd1);
      chk("gnt_issue", 32'(gnt), 32'd0);
      chk("rvalid_issue", 32'(rvalid), 32'd0);
      exp_rv = '0;
      if (!is_wr) begin
        for (int j = 0; j < RD_LAT; j++) begin
          @(posedge clk); #1;
          if (j == 0 && late != 0) begin
            for (int i = 0; i < NM; i++) begin
              if (late[i] && !pend[i]) begin
                randomize_master(i);
                pend[i] = 1'b1;
              end
            end
            late = '0;
            drive(pend);
          end
          @(negedge clk);
          chk("strobe_wait", 32'({xa_wr_s, xa_rd_s}), 32'd0);
          chk("gnt_wait", 32'(gnt), 32'd0);
          chk("busy_wait", 32'(busy), 32'd1);
          chk("rvalid_wait", 32'(rvalid), 32'd0);
          chk("xa_addr_hold", 32'(xa_addr), 32'(a));
        end
        exp_rv = NM'(1) << w;
        exp_rd = tgt_fn(a) ^ 16'(gcyc + 1 + RD_LAT);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("gnt_end", 32'(gnt), 32'd0);
    chk("busy_end", 32'(busy), 32'd0);
    chk("rvalid_end", 32'(rvalid), 32'(exp_rv));
    if (exp_rv != 0) chk("rdata_end", 32'(rdata), 32'(exp_rd));
    @(negedge clk);
    chk("rvalid_pulse", 32'(rvalid), 32'd0);
    if (exp_rv != 0) chk("rdata_hold", 32'(rdata), 32'(exp_rd));
  endtask

  task automatic chk_all_clear(input string tag);
    chk({tag, "_gnt"},    32'(gnt), 32'd0);
    chk({tag, "_busy"},   32'(busy), 32'd0);
    chk({tag, "_wr_s"},   32'(xa_wr_s), 32'd0);
    chk({tag, "_rd_s"},   32'(xa_rd_s), 32'd0);
    chk({tag, "_addr"},   32'(xa_addr), 32'd0);
    chk({tag, "_wdata"},  32'(xa_data_wr), 32'd0);
    chk({tag, "_rdata"},  32'(rdata), 32'd0);
    chk({tag, "_rvalid"}, 32'(rvalid), 32'd0);
  endtask

  initial begin
    int w;
    rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
    for (int i = 0; i < NM; i++) begin
      m_we[i] = 1'b1; m_addr[i] = '0; m_wd[i] = '0;
    end
    @(posedge clk); #1;
    req = '1;
    @(negedge clk);
    chk_all_clear("reset");
    @(posedge clk); #1;
    rst = 1'b0; req = '0;
    @(negedge clk);
    chk("busy_after_reset", 32'(busy), 32'd0);

    m_we[0] = 1'b1; m_addr[0] = 16'h0010; m_wd[0] = 16'hBEEF;
    run_batch(4'b0001, 0, 4'b0000);

    m_we[1] = 1'b0; m_addr[1] = 16'h0042;
    run_batch(4'b0010, 0, 4'b0000);

    for (int i = 0; i < NM; i++) begin
      m_we[i] = 1'b1; m_addr[i] = 16'(16'h0100 + i); m_wd[i] = 16'(16'h5A00 + i);
    end
    run_batch(4'b1011, 0, 4'b0000);

    run_batch(4'b0011, 2, 4'b0000);

    m_we[0] = 1'b0; m_addr[0] = 16'h0123;
    run_batch(4'b0001, 0, 4'b0010);

    // Reset while a read is waiting on the target.
    m_we[0] = 1'b0; m_addr[0] = 16'h0777;
    m_we[1] = 1'b1; m_addr[1] = 16'h0888; m_wd[1] = 16'h1111;
    @(posedge clk); #1;
    drive(4'b0001);
    @(negedge clk);
    w = pick(4'b0001, m_last);
    chk("rst_test_gnt", 32'(gnt), 32'(NM'(1) << w));
    @(posedge clk); #1;
    drive(4'b0000);
    @(posedge clk); #1;
    rst = 1'b1;
    m_we[0] = 1'b1; m_wd[0] = 16'h2222;
    drive(4'b0011);
    #1;
    chk_all_clear("midrst");
    m_last = NM - 1; last_wd = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    drive(4'b0000);
    for (int j = 0; j < RD_LAT + 3; j++) begin
      @(negedge clk);
      chk("post_rst_rvalid", 32'(rvalid), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);
    end
    run_batch(4'b0011, 0, 4'b0000);

    for (int it = 0; it < 30; it++) begin
      logic [NM-1:0] mask;
      mask = NM'($urandom_range(1, (1 << NM) - 1));
      for (int i = 0; i < NM; i++) randomize_master(i);
      run_batch(mask, $urandom_range(0, 2), NM'($urandom_range(0, (1 << NM) - 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sif_arbiter.md
Name: sif_arbiter

Overview:
- Shares one SIF target access port (xa_wr_s / xa_rd_s / xa_addr / xa_data_wr in, xa_data_rd out) between N_MST requesting masters.
- Uses round-robin arbitration and issues one single-cycle strobe per granted request.
- For reads, waits a fixed target read latency, captures xa_data_rd and returns it to the owning master with a one-cycle valid pulse.
- Sits between bus masters (test sequencers, config engines) and the SIF DUT.

Parameters:
- N_MST, 2, number of requesting masters (2..8)
- AW, 16, address width
- DW, 16, data width
- RD_LAT, 2, cycles from the xa_rd_s cycle to the cycle xa_data_rd is valid (1..15)

Ports:
- clk  input  1  clock, all logic on posedge
- rst  input  1  asynchronous reset, active-high
- req  input  N_MST  per-master request; held with we/addr/wdata stable until gnt
- we  input  N_MST  per-master direction: 1 = write, 0 = read
- addr  input  N_MST*AW  per-master address, packed, master i at [i*AW +: AW]
- wdata  input  N_MST*DW  per-master write data, packed
- gnt  output  N_MST  one-hot grant, single-cycle pulse
- rvalid  output  N_MST  one-hot read-return pulse to the owning master
- rdata  output  DW  read data, shared, valid when any rvalid bit is set
- busy  output  1  high whenever state != IDLE
- xa_wr_s  output  1  target write strobe
- xa_rd_s  output  1  target read strobe
- xa_addr  output  AW  target address
- xa_data_wr  output  DW  target write data
- xa_data_rd  input  DW  target read data

Behaviour:
- Reset values: all registered outputs = 0 (xa_wr_s, xa_rd_s, xa_addr, xa_data_wr, rdata, rvalid); state = IDLE; rr pointer = N_MST-1, so master 0 has first priority; read counter = 0; owner = 0. gnt is forced to 0 while rst is high.
- FSM states:
  - IDLE: if any req is set, gnt = one-hot winner (combinational, this cycle). At the clock edge, register the winner's addr and wdata to xa_addr / xa_data_wr, latch owner and we, update the pointer to the winner, and go to ISSUE. If no req is set, stay in IDLE.
  - ISSUE: exactly one cycle with xa_wr_s = we_latched or xa_rd_s = !we_latched. A write goes to IDLE next. A read loads cnt = RD_LAT-1 and goes to WAIT_RD.
  - WAIT_RD: decrement cnt each cycle. When cnt == 0, capture xa_data_rd into rdata and set rvalid[owner] for the next cycle, then go to IDLE.
- Timing with gnt in cycle T:
  - Strobe is in cycle T+1.
  - xa_data_rd is sampled in cycle T+1+RD_LAT.
  - rdata / rvalid are valid in cycle T+2+RD_LAT, which is also an IDLE cycle, so a new gnt can coincide with rvalid.
- Throughput: a write occupies 2 cycles; a read occupies RD_LAT+2 cycles.
- Round-robin: search starts at pointer+1 modulo N_MST; the first set req wins. The pointer changes only on a grant.
- Handshake:
  - The master samples gnt at the edge and must drop req, or present a new request, in the following cycle.
  - No gnt is issued outside IDLE; req held during ISSUE or WAIT_RD simply waits.
- Strobes are exactly one cycle and are mutually exclusive. xa_addr and xa_data_wr hold their last value after the strobe. A read does not modify xa_data_wr.
- rdata holds its value until the next capture. rvalid is a single-cycle pulse.
- Reset mid-operation (any state): outputs clear immediately and asynchronously. Any pending read is discarded, with no rvalid after release. The pointer returns to N_MST-1.
- req for a master changing while another master is being served has no effect until IDLE.
- RD_LAT outside 1..15 is rejected by an elaboration-time assertion.

Decomposition:
- Package sif_arb_pkg:
  - state enum typedef (IDLE, ISSUE, WAIT_RD)
  - default AW/DW constants
  - function next_rr(req, ptr) returning a one-hot winner
- Sub-module rr_pick:
  - combinational round-robin selector, inputs req[N_MST] and ptr, outputs one-hot win and win_idx
  - instantiated once
- The FSM, command registers and read counter live in sif_arbiter.

Test Plan:
1. Single write: req[0]=1, we[0]=1, addr0=0x0010, wdata0=0xBEEF -> gnt[0] in cycle T; xa_wr_s=1 with xa_addr=0x0010, xa_data_wr=0xBEEF in T+1 only; busy=1 in T+1; xa_rd_s never high.
2. Single read (RD_LAT=2): req[1]=1, we[1]=0, addr1=0x0042; target drives 0x1234 in T+3 -> xa_rd_s in T+1; rvalid=2'b10 and rdata=0x1234 in T+4; rdata still 0x1234 in T+5.
3. Contention: req=2'b11 held (both writes, each master re-requests after gnt) -> gnt order 0,1,0,1; xa_wr_s every second cycle; each xa_addr matches the granted master.
4. Request during read: master 0 read in flight, req[1] rises in T+2 -> no gnt until T+4; gnt[1] coincides with rvalid[0].
5. Reset in WAIT_RD: assert rst in T+2 for 2 cycles -> all outputs 0 immediately; no rvalid after release; next req=2'b11 grants master 0.
6. N_MST=4, last grant to master 1, req=4'b1011 -> gnt=4'b1000 (master 3), then gnt=4'b0001 on the next arbitration.
